// File: rtl/alu_uop_sequencer.sv
// Micro-op sequencer for the 65HE06 16-bit ALU/AGU datapath: steps REG, LOAD, STORE and
// (with `SEQ_RMW_EN defined) read-modify-write micro-ops through the ALU, register file and LSU.
module alu_uop_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uop_valid,
   output logic        uop_ready,
   input  logic [1:0]  uop_kind,
   input  logic [3:0]  uop_alu_f,
   input  logic        uop_carry,
   input  logic [15:0] uop_imm,
   input  logic        uop_use_imm,
   input  logic        uop_zero_index,
   input  logic [2:0]  uop_ra,
   input  logic [2:0]  uop_rb,
   input  logic [2:0]  uop_rd,
   input  logic        uop_wf,
   output logic [3:0]  alu_f,
   output logic        carry_mask,
   output logic [15:0] sched_t16,
   output logic [15:0] sched_agu_t16,
   output logic        sched_bypass_b,
   output logic        sched_zero_index,
   output logic [2:0]  rf_a_sel,
   output logic [2:0]  rf_b_sel,
   output logic [2:0]  rf_d_sel,
   output logic        rf_d_we,
   output logic        rf_sf_we,
   output logic        lsu_req,
   output logic        lsu_we,
   input  logic        lsu_ack,
   input  logic [15:0] lsu_rdata,
   output logic        uop_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_EXEC   = 3'd1,
      S_LD_REQ = 3'd2,
      S_LD_WB  = 3'd3,
      S_ST_REQ = 3'd4,
      S_RMW_LD = 3'd5,
      S_RMW_OP = 3'd6,
      S_RMW_ST = 3'd7
   } state_t;

   localparam logic [1:0] K_REG   = 2'd0;
   localparam logic [1:0] K_LOAD  = 2'd1;
   localparam logic [1:0] K_STORE = 2'd2;
   localparam logic [1:0] K_RMW   = 2'd3;

   state_t      r_state;
   state_t      w_next;

   logic [3:0]  r_alu_f;
   logic        r_carry;
   logic [15:0] r_imm;
   logic        r_use_imm;
   logic        r_zero_index;
   logic [2:0]  r_ra;
   logic [2:0]  r_rb;
   logic [2:0]  r_rd;
   logic        r_wf;
   logic [15:0] r_ldata;

   logic        w_accept;
   logic        w_load_ack;

   assign uop_ready  = (r_state == S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign w_accept   = uop_valid && uop_ready;
   assign w_load_ack = lsu_ack && ((r_state == S_LD_REQ) || (r_state == S_RMW_LD));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Every field is frozen at acceptance so the datapath controls stay stable for the whole micro-op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_f      <= 4'd0;
         r_carry      <= 1'b0;
         r_imm        <= 16'd0;
         r_use_imm    <= 1'b0;
         r_zero_index <= 1'b0;
         r_ra         <= 3'd0;
         r_rb         <= 3'd0;
         r_rd         <= 3'd0;
         r_wf         <= 1'b0;
      end else if (w_accept) begin
         r_alu_f      <= uop_alu_f;
         r_carry      <= uop_carry;
         r_imm        <= uop_imm;
         r_use_imm    <= uop_use_imm;
         r_zero_index <= uop_zero_index;
         r_ra         <= uop_ra;
         r_rb         <= uop_rb;
         r_rd         <= uop_rd;
         r_wf         <= uop_wf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ldata <= 16'd0;
      end else if (w_load_ack) begin
         r_ldata <= lsu_rdata;
      end
   end

`ifdef SEQ_RMW_EN
   assign uop_err = 1'b0;
`else
   // RMW is unsupported in this build: it is consumed and flagged, never executed.
   logic r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_accept && (uop_kind == K_RMW);
      end
   end

   assign uop_err = r_err;
`endif

   always_comb begin
      w_next           = r_state;
      alu_f            = 4'd0;
      carry_mask       = 1'b0;
      sched_t16        = 16'd0;
      sched_agu_t16    = 16'd0;
      sched_bypass_b   = 1'b0;
      sched_zero_index = 1'b0;
      rf_a_sel         = 3'd0;
      rf_b_sel         = 3'd0;
      rf_d_sel         = 3'd0;
      rf_d_we          = 1'b0;
      rf_sf_we         = 1'b0;
      lsu_req          = 1'b0;
      lsu_we           = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (uop_valid) begin
               case (uop_kind)
                  K_REG:   w_next = S_EXEC;
                  K_LOAD:  w_next = S_LD_REQ;
                  K_STORE: w_next = S_ST_REQ;
`ifdef SEQ_RMW_EN
                  K_RMW:   w_next = S_RMW_LD;
`else
                  K_RMW:   w_next = S_IDLE;
`endif
                  default: w_next = S_IDLE;
               endcase
            end
         end

         S_EXEC: begin
            alu_f          = r_alu_f;
            carry_mask     = r_carry;
            sched_bypass_b = r_use_imm;
            sched_t16      = r_imm;
            rf_a_sel       = r_ra;
            rf_b_sel       = r_rb;
            rf_d_sel       = r_rd;
            rf_d_we        = 1'b1;
            rf_sf_we       = r_wf;
            w_next         = S_IDLE;
         end

         S_LD_REQ: begin
            lsu_req          = 1'b1;
            sched_agu_t16    = r_imm;
            sched_zero_index = r_zero_index;
            rf_a_sel         = r_ra;
            if (lsu_ack) w_next = S_LD_WB;
         end

         S_LD_WB: begin
            alu_f          = r_alu_f;
            carry_mask     = r_carry;
            sched_bypass_b = 1'b1;
            sched_t16      = r_ldata;
            rf_a_sel       = r_ra;
            rf_d_sel       = r_rd;
            rf_d_we        = 1'b1;
            rf_sf_we       = r_wf;
            w_next         = S_IDLE;
         end

         S_ST_REQ: begin
            lsu_req          = 1'b1;
            lsu_we           = 1'b1;
            sched_agu_t16    = r_imm;
            sched_zero_index = r_zero_index;
            rf_a_sel         = r_ra;
            rf_b_sel         = r_rb;
            if (lsu_ack) w_next = S_IDLE;
         end

`ifdef SEQ_RMW_EN
         S_RMW_LD: begin
            lsu_req          = 1'b1;
            sched_agu_t16    = r_imm;
            sched_zero_index = r_zero_index;
            rf_a_sel         = r_ra;
            if (lsu_ack) w_next = S_RMW_OP;
         end

         S_RMW_OP: begin
            alu_f          = r_alu_f;
            carry_mask     = r_carry;
            sched_bypass_b = 1'b1;
            sched_t16      = r_ldata;
            rf_a_sel       = r_ra;
            rf_d_sel       = r_rd;
            rf_d_we        = 1'b1;
            rf_sf_we       = r_wf;
            w_next         = S_RMW_ST;
         end

         // The modified value was just written to rd, so rd is the store payload.
         S_RMW_ST: begin
            lsu_req          = 1'b1;
            lsu_we           = 1'b1;
            sched_agu_t16    = r_imm;
            sched_zero_index = r_zero_index;
            rf_a_sel         = r_ra;
            rf_b_sel         = r_rd;
            if (lsu_ack) w_next = S_IDLE;
         end
`endif

         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_uop_sequencer.sv
// Directed bench for alu_uop_sequencer; follows the RMW behaviour selected by SEQ_RMW_EN.
module tb_alu_uop_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        uop_valid;
   logic        uop_ready;
   logic [1:0]  uop_kind;
   logic [3:0]  uop_alu_f;
   logic        uop_carry;
   logic [15:0] uop_imm;
   logic        uop_use_imm;
   logic        uop_zero_index;
   logic [2:0]  uop_ra, uop_rb, uop_rd;
   logic        uop_wf;
   logic [3:0]  alu_f;
   logic        carry_mask;
   logic [15:0] sched_t16, sched_agu_t16;
   logic        sched_bypass_b, sched_zero_index;
   logic [2:0]  rf_a_sel, rf_b_sel, rf_d_sel;
   logic        rf_d_we, rf_sf_we;
   logic        lsu_req, lsu_we, lsu_ack;
   logic [15:0] lsu_rdata;
   logic        uop_err, busy;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_uop_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_kind(uop_kind),
      .uop_alu_f(uop_alu_f), .uop_carry(uop_carry), .uop_imm(uop_imm),
      .uop_use_imm(uop_use_imm), .uop_zero_index(uop_zero_index),
      .uop_ra(uop_ra), .uop_rb(uop_rb), .uop_rd(uop_rd), .uop_wf(uop_wf),
      .alu_f(alu_f), .carry_mask(carry_mask), .sched_t16(sched_t16),
      .sched_agu_t16(sched_agu_t16), .sched_bypass_b(sched_bypass_b),
      .sched_zero_index(sched_zero_index),
      .rf_a_sel(rf_a_sel), .rf_b_sel(rf_b_sel), .rf_d_sel(rf_d_sel),
      .rf_d_we(rf_d_we), .rf_sf_we(rf_sf_we),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_ack(lsu_ack), .lsu_rdata(lsu_rdata),
      .uop_err(uop_err), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // All non-ready outputs packed together; must be zero whenever the sequencer is idle.
   function automatic logic [76:0] all_out();
      return {alu_f, carry_mask, sched_t16, sched_agu_t16, sched_bypass_b, sched_zero_index,
              rf_a_sel, rf_b_sel, rf_d_sel, rf_d_we, rf_sf_we, lsu_req, lsu_we, uop_err, busy};
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, ".ready"}, {31'd0, uop_ready}, 32'd1);
      chk({tag, ".outs_zero"}, {31'd0, (all_out() != 77'd0)}, 32'd0);
   endtask

   task automatic put_uop(input logic [1:0] k, input logic [3:0] f, input logic c,
                          input logic [15:0] imm, input logic ui, input logic zi,
                          input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                          input logic wf);
      uop_kind = k; uop_alu_f = f; uop_carry = c; uop_imm = imm; uop_use_imm = ui;
      uop_zero_index = zi; uop_ra = ra; uop_rb = rb; uop_rd = rd; uop_wf = wf;
      uop_valid = 1'b1;
   endtask

   task automatic scramble();
      uop_kind = 2'd0; uop_alu_f = 4'hF; uop_carry = 1'b0; uop_imm = 16'hDEAD;
      uop_use_imm = 1'b0; uop_zero_index = 1'b0; uop_ra = 3'd7; uop_rb = 3'd7;
      uop_rd = 3'd7; uop_wf = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; uop_valid = 1'b0; lsu_ack = 1'b0; lsu_rdata = 16'h0000;
      scramble();
      repeat (3) @(negedge clk);
      chk_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("post_reset");

      // REG with immediate
      put_uop(2'd0, 4'b0000, 1'b0, 16'h0005, 1'b1, 1'b0, 3'd1, 3'd0, 3'd2, 1'b1);
      @(negedge clk);
      uop_valid = 1'b0; scramble();
      chk("reg_imm.busy", {31'd0, busy}, 32'd1);
      chk("reg_imm.ready", {31'd0, uop_ready}, 32'd0);
      chk("reg_imm.bypass", {31'd0, sched_bypass_b}, 32'd1);
      chk("reg_imm.t16", {16'd0, sched_t16}, 32'h0005);
      chk("reg_imm.d_sel", {29'd0, rf_d_sel}, 32'd2);
      chk("reg_imm.we", {30'd0, rf_d_we, rf_sf_we}, 32'd3);
      chk("reg_imm.lsu", {31'd0, lsu_req}, 32'd0);
      @(negedge clk);
      chk_idle("reg_imm.done");

      // REG register-register with carry, no flag write
      put_uop(2'd0, 4'b0011, 1'b1, 16'h1234, 1'b0, 1'b0, 3'd1, 3'd6, 3'd5, 1'b0);
      @(negedge clk);
      uop_valid = 1'b0; scramble();
      chk("reg_rr.alu", {27'd0, alu_f, carry_mask}, {27'd0, 4'b0011, 1'b1});
      chk("reg_rr.sels", {23'd0, rf_a_sel, rf_b_sel, rf_d_sel}, {23'd0, 3'd1, 3'd6, 3'd5});
      chk("reg_rr.bypass_t16", {15'd0, sched_bypass_b, sched_t16}, {15'd0, 1'b0, 16'h1234});
      chk("reg_rr.we", {30'd0, rf_d_we, rf_sf_we}, 32'd2);
      @(negedge clk);

      // ack while idle must be ignored
      lsu_ack = 1'b1;
      @(negedge clk);
      lsu_ack = 1'b0;
      chk_idle("stray_ack");

      // LOAD with 3 wait cycles; a STORE waits on uop_valid meanwhile
      put_uop(2'd1, 4'b0111, 1'b0, 16'h0010, 1'b0, 1'b1, 3'd2, 3'd0, 3'd3, 1'b1);
      @(negedge clk);
      put_uop(2'd2, 4'b0000, 1'b0, 16'h0200, 1'b0, 1'b0, 3'd0, 3'd5, 3'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("load.req%0d", i), {15'd0, lsu_req, lsu_we, sched_zero_index,
             rf_d_we, 13'd0}, {15'd0, 1'b1, 1'b0, 1'b1, 1'b0, 13'd0});
         chk($sformatf("load.agu%0d", i), {16'd0, sched_agu_t16}, 32'h0010);
         chk($sformatf("load.ready%0d", i), {31'd0, uop_ready}, 32'd0);
         if (i == 3) begin
            lsu_ack = 1'b1; lsu_rdata = 16'hBEEF;
         end
         @(negedge clk);
      end
      lsu_ack = 1'b0; lsu_rdata = 16'h0000;
      chk("load_wb.t16", {16'd0, sched_t16}, 32'hBEEF);
      chk("load_wb.ctl", {25'd0, alu_f, sched_bypass_b, rf_d_we, lsu_req},
          {25'd0, 4'b0111, 1'b1, 1'b1, 1'b0});
      chk("load_wb.sels", {26'd0, rf_a_sel, rf_d_sel}, {26'd0, 3'd2, 3'd3});
      @(negedge clk);
      chk("load.ready", {31'd0, uop_ready}, 32'd1);

      // the held STORE is taken now, zero-wait ack
      @(negedge clk);
      uop_valid = 1'b0; scramble();
      chk("store.lsu", {30'd0, lsu_req, lsu_we}, 32'd3);
      chk("store.b_sel", {29'd0, rf_b_sel}, 32'd5);
      chk("store.agu", {16'd0, sched_agu_t16}, 32'h0200);
      chk("store.no_wr", {30'd0, rf_d_we, rf_sf_we}, 32'd0);
      lsu_ack = 1'b1;
      @(negedge clk);
      lsu_ack = 1'b0;
      chk_idle("store.done");

      // RMW
      put_uop(2'd3, 4'b0001, 1'b0, 16'h0040, 1'b0, 1'b0, 3'd2, 3'd0, 3'd4, 1'b1);
      @(negedge clk);
      uop_valid = 1'b0; scramble();
`ifdef SEQ_RMW_EN
      chk("rmw_ld.lsu", {30'd0, lsu_req, lsu_we}, 32'd2);
      chk("rmw_ld.agu", {16'd0, sched_agu_t16}, 32'h0040);
      lsu_ack = 1'b1; lsu_rdata = 16'h00FF;
      @(negedge clk);
      lsu_ack = 1'b0; lsu_rdata = 16'h0000;
      chk("rmw_op.t16", {16'd0, sched_t16}, 32'h00FF);
      chk("rmw_op.wr", {26'd0, rf_d_sel, rf_d_we, lsu_req, uop_err},
          {26'd0, 3'd4, 1'b1, 1'b0, 1'b0});
      chk("rmw_op.alu", {28'd0, alu_f}, 32'd1);
      @(negedge clk);
      chk("rmw_st.lsu", {29'd0, lsu_req, lsu_we, rf_d_we}, 32'd6);
      chk("rmw_st.b_sel", {29'd0, rf_b_sel}, 32'd4);
      lsu_ack = 1'b1;
      @(negedge clk);
      lsu_ack = 1'b0;
      chk_idle("rmw.done");
`else
      chk("rmw_err.pulse", {31'd0, uop_err}, 32'd1);
      chk("rmw_err.idle", {28'd0, uop_ready, busy, lsu_req, rf_d_we}, 32'b1000);
      @(negedge clk);
      chk_idle("rmw_err.done");
`endif

      // asynchronous reset during LD_REQ
      put_uop(2'd1, 4'b0010, 1'b1, 16'h0300, 1'b0, 1'b0, 3'd1, 3'd0, 3'd6, 1'b1);
      @(negedge clk);
      uop_valid = 1'b0;
      chk("areset.req_before", {31'd0, lsu_req}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("areset.req_drop", {31'd0, lsu_req}, 32'd0);
      chk("areset.ready", {31'd0, uop_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("areset.after");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
